// File: rtl/tw_pkg.sv
// Shared types and constants for the tw_core accumulator machine.
package tw_pkg;

    typedef enum logic [3:0] {
        OP_ADD_A  = 4'd0,
        OP_MOV_AB = 4'd1,
        OP_IN_A   = 4'd2,
        OP_MOV_AI = 4'd3,
        OP_MOV_BA = 4'd4,
        OP_ADD_B  = 4'd5,
        OP_IN_B   = 4'd6,
        OP_MOV_BI = 4'd7,
        OP_NOP0   = 4'd8,
        OP_OUT_B  = 4'd9,
        OP_NOP1   = 4'd10,
        OP_OUT_I  = 4'd11,
        OP_SWAP   = 4'd12,
        OP_TRAP   = 4'd13,
        OP_JNC    = 4'd14,
        OP_JMP    = 4'd15
    } opcode_e;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_e;

    localparam logic MODE_USER = 1'b0;
    localparam logic MODE_PRIV = 1'b1;

endpackage

// File: rtl/tw_alu.sv
// Combinational datapath for the A/B register instructions of tw_core.
module tw_alu
    import tw_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  opcode_e           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] imm,
    input  logic [DATA_W-1:0] in_port,
    output logic [DATA_W-1:0] a_new,
    output logic [DATA_W-1:0] b_new,
    output logic              c_new,
    output logic              a_we,
    output logic              b_we
);

    logic [DATA_W:0] sum_a;
    logic [DATA_W:0] sum_b;

    assign sum_a = {1'b0, a} + {1'b0, imm};
    assign sum_b = {1'b0, b} + {1'b0, imm};

    // Carry is only ever set by ADD; all other opcodes return c_new=0.
    always_comb begin
        a_new = a;
        b_new = b;
        c_new = 1'b0;
        a_we  = 1'b0;
        b_we  = 1'b0;
        case (op)
            OP_ADD_A: begin
                a_new = sum_a[DATA_W-1:0];
                c_new = sum_a[DATA_W];
                a_we  = 1'b1;
            end
            OP_MOV_AB: begin
                a_new = b;
                a_we  = 1'b1;
            end
            OP_IN_A: begin
                a_new = in_port;
                a_we  = 1'b1;
            end
            OP_MOV_AI: begin
                a_new = imm;
                a_we  = 1'b1;
            end
            OP_MOV_BA: begin
                b_new = a;
                b_we  = 1'b1;
            end
            OP_ADD_B: begin
                b_new = sum_b[DATA_W-1:0];
                c_new = sum_b[DATA_W];
                b_we  = 1'b1;
            end
            OP_IN_B: begin
                b_new = in_port;
                b_we  = 1'b1;
            end
            OP_MOV_BI: begin
                b_new = imm;
                b_we  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/tw_core.sv
// tw_core: parametrised TD4-class accumulator core with user/privileged banks,
// SWI/IRET traps and a valid/ack fetch port. Hardware IRQ enabled by TW_IRQ_EN.
//
// state | meaning
// BOOT  | single cycle after reset release, no fetch yet
// FETCH | imem_req high, waiting for imem_ack to latch the instruction
// EXEC  | latched instruction commits, pc/mode/trap update
module tw_core
    import tw_pkg::*;
#(
    parameter int DATA_W  = 4,
    parameter int ADDR_W  = 4,
    parameter int IRQ_VEC = 1
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W+3:0] imem_data,
    input  logic [DATA_W-1:0] in_port,
    output logic [DATA_W-1:0] out_port,
    output logic              priv,
    input  logic              irq,
    output logic              irq_ack
);

    typedef struct packed {
        opcode_e           op;
        logic [DATA_W-1:0] imm;
    } instr_t;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic              c;
    } bank_t;

    localparam logic [ADDR_W-1:0] IRQ_PC = ADDR_W'(IRQ_VEC);

    state_e            state_q, state_d;
    logic              req_q, req_d;
    instr_t            instr_q, instr_d;
    logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, jmp_pc;
    logic              priv_q, priv_d;
    logic [ADDR_W-1:0] saved_pc_q, saved_pc_d;
    bank_t             usr_q, usr_d, prv_q, prv_d, act, act_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              irq_take;

    logic [DATA_W-1:0] alu_a, alu_b;
    logic              alu_c, alu_a_we, alu_b_we;

    assign act    = (priv_q == MODE_PRIV) ? prv_q : usr_q;
    assign pc_inc = pc_q + ADDR_W'(1);
    assign jmp_pc = ADDR_W'(instr_q.imm);

    tw_alu #(.DATA_W(DATA_W)) u_alu (
        .op      (instr_q.op),
        .a       (act.a),
        .b       (act.b),
        .imm     (instr_q.imm),
        .in_port (in_port),
        .a_new   (alu_a),
        .b_new   (alu_b),
        .c_new   (alu_c),
        .a_we    (alu_a_we),
        .b_we    (alu_b_we)
    );

`ifdef TW_IRQ_EN
    // Opcode 13 in user mode is SWI; it must not be overtaken by an IRQ.
    assign irq_take = (priv_q == MODE_USER) && irq && (instr_q.op != OP_TRAP);

    logic irq_ack_q;
    always_ff @(posedge clock) begin
        if (!reset) begin
            irq_ack_q <= 1'b0;
        end else begin
            irq_ack_q <= (state_q == EXEC) && irq_take;
        end
    end
    assign irq_ack = irq_ack_q;
`else
    logic unused_irq;
    assign unused_irq = irq ^ IRQ_PC[0];
    assign irq_take   = 1'b0;
    assign irq_ack    = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        req_d      = 1'b0;
        instr_d    = instr_q;
        pc_d       = pc_q;
        priv_d     = priv_q;
        saved_pc_d = saved_pc_q;
        usr_d      = usr_q;
        prv_d      = prv_q;
        act_d      = act;
        out_d      = out_q;
        unique case (state_q)
            BOOT: begin
                state_d = FETCH;
                req_d   = 1'b1;
            end
            FETCH: begin
                req_d = 1'b1;
                if (imem_ack) begin
                    state_d = EXEC;
                    req_d   = 1'b0;
                    instr_d = instr_t'(imem_data);
                end
            end
            EXEC: begin
                state_d = FETCH;
                req_d   = 1'b1;
                pc_d    = pc_inc;
                if (alu_a_we) act_d.a = alu_a;
                if (alu_b_we) act_d.b = alu_b;
                act_d.c = alu_c;
                if (priv_q == MODE_PRIV) prv_d = act_d;
                else                     usr_d = act_d;
                case (instr_q.op)
                    OP_OUT_B: out_d = act.b;
                    OP_OUT_I: out_d = instr_q.imm;
                    OP_SWAP: begin
                        if (priv_q == MODE_PRIV) begin
                            if (instr_q.imm[0]) begin
                                prv_d.b = usr_q.b;
                                usr_d.b = prv_q.b;
                            end else begin
                                prv_d.a = usr_q.a;
                                usr_d.a = prv_q.a;
                            end
                        end
                    end
                    OP_TRAP: begin
                        if (priv_q == MODE_USER) begin
                            saved_pc_d = pc_inc;
                            priv_d     = MODE_PRIV;
                            pc_d       = '0;
                        end else begin
                            priv_d = MODE_USER;
                            pc_d   = saved_pc_q;
                        end
                    end
                    OP_JNC:  if (!act.c) pc_d = jmp_pc;
                    OP_JMP:  pc_d = jmp_pc;
                    default: ;
                endcase
                // The instruction has fully committed; the interrupt redirects its next pc.
                if (irq_take) begin
                    saved_pc_d = pc_d;
                    priv_d     = MODE_PRIV;
                    pc_d       = IRQ_PC;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= BOOT;
            req_q      <= 1'b0;
            instr_q    <= '0;
            pc_q       <= '0;
            priv_q     <= MODE_USER;
            saved_pc_q <= '0;
            usr_q      <= '0;
            prv_q      <= '0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            priv_q     <= priv_d;
            saved_pc_q <= saved_pc_d;
            usr_q      <= usr_d;
            prv_q      <= prv_d;
            out_q      <= out_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = {priv_q, pc_q};
    assign out_port  = out_q;
    assign priv      = priv_q;

endmodule

// File: tb/tb_tw_core.sv
// Directed self-checking bench for tw_core: default instance plus an 8-bit/6-bit instance.
module tb_tw_core;
    import tw_pkg::*;

    logic        clock;
    logic        reset;
    logic        reset_w;
    logic        irq;
    logic        irq_w;

    logic        imem_req0;
    logic [4:0]  imem_addr0;
    logic        imem_ack0;
    logic [7:0]  imem_data0;
    logic [3:0]  in_port0;
    logic [3:0]  out_port0;
    logic        priv0;
    logic        irq_ack0;

    logic        imem_req1;
    logic [6:0]  imem_addr1;
    logic        imem_ack1;
    logic [11:0] imem_data1;
    logic [7:0]  in_port1;
    logic [7:0]  out_port1;
    logic        priv1;
    logic        irq_ack1;

    logic [7:0]  rom0 [32];
    logic [11:0] rom1 [128];
    int          wcnt;
    int          ack_delay;
    int          n_checks;
    int          n_errors;

    tw_core u0 (
        .clock     (clock),
        .reset     (reset),
        .imem_req  (imem_req0),
        .imem_addr (imem_addr0),
        .imem_ack  (imem_ack0),
        .imem_data (imem_data0),
        .in_port   (in_port0),
        .out_port  (out_port0),
        .priv      (priv0),
        .irq       (irq),
        .irq_ack   (irq_ack0)
    );

    tw_core #(.DATA_W(8), .ADDR_W(6), .IRQ_VEC(1)) u1 (
        .clock     (clock),
        .reset     (reset_w),
        .imem_req  (imem_req1),
        .imem_addr (imem_addr1),
        .imem_ack  (imem_ack1),
        .imem_data (imem_data1),
        .in_port   (in_port1),
        .out_port  (out_port1),
        .priv      (priv1),
        .irq       (irq_w),
        .irq_ack   (irq_ack1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign imem_data0 = rom0[imem_addr0];
    assign imem_data1 = rom1[imem_addr1];
    assign imem_ack0  = imem_req0 && (wcnt >= ack_delay);
    assign imem_ack1  = imem_req1;

    always @(posedge clock) begin
        if (!imem_req0 || imem_ack0) wcnt <= 0;
        else                         wcnt <= wcnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic load_nops0();
        for (int i = 0; i < 32; i++) rom0[i] = 8'h80;
    endtask

    task automatic restart0();
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        wcnt      = 0;
        ack_delay = 0;
        reset     = 1'b0;
        reset_w   = 1'b0;
        irq       = 1'b0;
        irq_w     = 1'b0;
        in_port0  = 4'h6;
        in_port1  = 8'h00;
        for (int i = 0; i < 128; i++) rom1[i] = 12'h800;

        // Basic program {MOV A,5; ADD A,12; JNC 0; OUT 9}, then IN A at pc 4.
        load_nops0();
        rom0[0] = 8'h35;
        rom0[1] = 8'h0C;
        rom0[2] = 8'hE0;
        rom0[3] = 8'hB9;
        rom0[4] = 8'h20;
        tick(3);
        chk("rst_req",      32'(imem_req0), 0);
        chk("rst_addr",     32'(imem_addr0), 0);
        chk("rst_out",      32'(out_port0), 0);
        chk("rst_priv",     32'(priv0), 0);
        chk("rst_irq_ack",  32'(irq_ack0), 0);
        chk("rst_state",    32'(u0.state_q), 32'(BOOT));
        chk("rst_saved_pc", 32'(u0.saved_pc_q), 0);
        reset = 1'b1;
        tick(1);
        chk("first_req", 32'(imem_req0), 1);
        tick(2);
        chk("mov_a_imm", 32'(u0.usr_q.a), 5);
        tick(2);
        chk("add_a_wrap", 32'(u0.usr_q.a), 1);
        chk("add_a_carry", 32'(u0.usr_q.c), 1);
        tick(2);
        chk("jnc_not_taken", 32'(imem_addr0), 3);
        chk("jnc_clears_c", 32'(u0.usr_q.c), 0);
        tick(2);
        chk("out_imm", 32'(out_port0), 9);
        chk("pc_after_out", 32'(imem_addr0), 4);

        // Fetch wait of 3 cycles: 5 cycles per instruction, address held.
        ack_delay = 3;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("wait_addr_hold", 32'(imem_addr0), 4);
            chk("wait_req_hold", 32'(imem_req0), 1);
        end
        tick(1);
        chk("wait_exec_req", 32'(imem_req0), 0);
        chk("wait_exec_addr", 32'(imem_addr0), 4);
        tick(1);
        chk("wait_next_addr", 32'(imem_addr0), 5);
        chk("in_a", 32'(u0.usr_q.a), 6);
        ack_delay = 0;

        // SWI at pc 4, handler {SWAP 0; IRET}, resume at pc 5.
        load_nops0();
        rom0[0]  = 8'h33;
        rom0[1]  = 8'hB7;
        rom0[4]  = 8'hD0;
        rom0[5]  = 8'h40;
        rom0[6]  = 8'h90;
        rom0[16] = 8'hC0;
        rom0[17] = 8'hD0;
        restart0();
        tick(5);
        chk("swi_pre_out", 32'(out_port0), 7);
        tick(6);
        chk("swi_priv", 32'(priv0), 1);
        chk("swi_addr", 32'(imem_addr0), 16);
        chk("swi_saved_pc", 32'(u0.saved_pc_q), 5);
        tick(2);
        chk("swap_user_a", 32'(u0.usr_q.a), 0);
        chk("swap_priv_a", 32'(u0.prv_q.a), 3);
        tick(2);
        chk("iret_priv", 32'(priv0), 0);
        chk("iret_addr", 32'(imem_addr0), 5);
        tick(4);
        chk("post_swap_out", 32'(out_port0), 0);

`ifdef TW_IRQ_EN
        // IRQ during MOV A,7 at pc 2; handler {NOP; IRET} at priv 1.
        load_nops0();
        rom0[2]  = 8'h37;
        rom0[18] = 8'hD0;
        restart0();
        tick(5);
        irq = 1'b1;
        tick(2);
        chk("irq_a_commit", 32'(u0.usr_q.a), 7);
        chk("irq_ack_pulse", 32'(irq_ack0), 1);
        chk("irq_priv", 32'(priv0), 1);
        chk("irq_addr", 32'(imem_addr0), 17);
        chk("irq_saved_pc", 32'(u0.saved_pc_q), 3);
        tick(1);
        chk("irq_ack_drop", 32'(irq_ack0), 0);
        tick(1);
        chk("irq_no_nest", 32'(imem_addr0), 18);
        tick(2);
        chk("irq_iret_priv", 32'(priv0), 0);
        chk("irq_iret_addr", 32'(imem_addr0), 3);
        chk("irq_iret_no_ack", 32'(irq_ack0), 0);
        tick(2);
        chk("irq_retake_priv", 32'(priv0), 1);
        chk("irq_retake_ack", 32'(irq_ack0), 1);
        chk("irq_retake_saved", 32'(u0.saved_pc_q), 4);
        irq = 1'b0;
`else
        // Without the IRQ feature, irq must have no effect.
        load_nops0();
        rom0[2] = 8'h37;
        restart0();
        tick(5);
        irq = 1'b1;
        tick(2);
        chk("noirq_priv", 32'(priv0), 0);
        chk("noirq_ack", 32'(irq_ack0), 0);
        chk("noirq_addr", 32'(imem_addr0), 3);
        irq = 1'b0;
`endif

        // Reset asserted during EXEC of OUT 5 aborts it.
        load_nops0();
        rom0[0] = 8'hB5;
        restart0();
        tick(2);
        reset = 1'b0;
        tick(1);
        chk("abort_out", 32'(out_port0), 0);
        chk("abort_state", 32'(u0.state_q), 32'(BOOT));
        chk("abort_req", 32'(imem_req0), 0);
        reset = 1'b1;
        tick(3);
        chk("rerun_out", 32'(out_port0), 5);

        // Wide instance: ADD carry and pc wrap after JMP 63.
        rom1[0] = 12'h301;
        rom1[1] = 12'h0FF;
        rom1[2] = 12'hF3F;
        reset_w = 1'b1;
        tick(3);
        chk("w_mov_a", 32'(u1.usr_q.a), 1);
        tick(2);
        chk("w_add_a", 32'(u1.usr_q.a), 0);
        chk("w_add_c", 32'(u1.usr_q.c), 1);
        tick(2);
        chk("w_jmp_63", 32'(imem_addr1), 63);
        tick(2);
        chk("w_wrap_0", 32'(imem_addr1), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
